mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM stage directly downstream of the execute stage. Registers the EX result (EX/MEM boundary).
//  Runs load/store transactions on a req/ack data bus, with byte-lane alignment and sign extension.
//  Stalls the pipeline while an access is in flight and drives registered WB/forwarding outputs.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  BUS_TIMEOUT  16  cycles in BUSY without ack before abort; 0 = never time out
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  ex_rd_addr_i    in   5   EX destination register
//  ex_rd_data_i    in   32  EX ALU/CSR/link result
//  ex_rd_wen_i     in   1   EX register write enable
//  ex_mem_addr_i   in   32  byte address of access
//  ex_mem_data_i   in   32  store data, right-aligned
//  ex_mem_size_i   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_mem_we_i     in   1   store request
//  ex_mem_re_i     in   1   load request
//  flush_i         in   1   squash the op currently presented by EX
//  bus_req_o       out  1   access request, held until ack or timeout
//  bus_we_o        out  1   1 = write
//  bus_addr_o      out  32  word address {addr[31:2],2'b00}
//  bus_wdata_o     out  32  store data replicated to lanes
//  bus_be_o        out  4   byte enables
//  bus_ack_i       in   1   access done; bus_rdata_i valid in the same cycle
//  bus_rdata_i     in   32  read word
//  wb_rd_addr_o    out  5   registered writeback address (also the forwarding source)
//  wb_rd_data_o    out  32  registered writeback data
//  wb_rd_wen_o     out  1   registered writeback enable
//  hold_flag_o     out  1   stall request to the control unit (combinational)
//  misalign_o      out  1   1-cycle pulse, registered
//  misalign_addr_o out  32  faulting address, held until the next fault
//  bus_err_o       out  1   1-cycle pulse on timeout, registered
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, every output 0.
//  FSM IDLE:
//   - flush_i=1: the presented op is squashed. Next cycle wb_rd_wen_o=0; no capture, no bus access.
//   - Non-memory op (we=re=0): 1-cycle pass-through, wb_* <= ex_rd_*; hold=0.
//   - Misaligned op: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//     No bus access, misalign_o pulses, misalign_addr_o <= addr, wb_rd_wen_o <= 0, hold=0.
//   - Aligned memory op: capture addr/data/size/we/rd into internal registers, hold_flag_o=1,
//     next state=BUSY, wb_rd_wen_o <= 0 (bubble).
//   - we and re both set: treated as a store.
//  FSM BUSY:
//   - bus_req_o=1 with the captured attributes, stable until ack.
//   - Ack cycle: hold_flag_o=0. On that edge the result is written to wb_*, state returns to IDLE, counter clears.
//     Loads: wb_rd_data_o = extracted load data, wb_rd_wen_o = captured rd_wen.
//     Stores: wb_rd_wen_o = 0.
//   - Not the ack cycle: hold_flag_o=1, counter increments, wb_rd_wen_o=0.
//   - Counter reaching BUS_TIMEOUT with no ack: req drops next cycle, bus_err_o pulses,
//     no writeback, state=IDLE, hold=0 in that cycle.
//   - flush_i is ignored in BUSY: an accepted access always completes.
//   - Ack in IDLE is ignored.
//  Timing: minimum occupancy is 2 cycles (capture cycle plus ack in the first BUSY cycle), i.e. 1 stall cycle.
//   The EX input is frozen by the hold, so it is never recaptured.
//  Lanes (off = addr[1:0]):
//   - Byte enables: B -> 4'b0001<<off; H -> 4'b0011<<off; W -> 4'b1111.
//   - Store wdata: B -> {4{d[7:0]}}; H -> {2{d[15:0]}}; W -> d.
//   - Load data: byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
//     B/H sign-extend; BU/HU zero-extend; W passes rdata unchanged.
//  Undefined size code: treated as W for alignment checks and lanes.
//  Reset mid-access: bus_req_o drops immediately (async), state=IDLE, no writeback.
// TESTING
//  - SW x=0xDEADBEEF @0x100, ack in 1st BUSY cycle -> be=1111, addr 0x100; hold high 1 cycle; wb_rd_wen_o=0.
//  - LB @0x103, rdata=0x80FF0011 -> wb_rd_data_o=0xFFFFFF80. Same access as LBU -> 0x00000080.
//  - LH @0x102, rdata=0x8001xxxx, ack after 3 wait cycles -> hold high 4 cycles; wb data=0xFFFF8001.
//  - LW @0x101 -> no bus_req, misalign_o pulse, misalign_addr_o=0x101, hold never set.
//  - BUS_TIMEOUT=4, no ack -> req high 4 cycles then drops, bus_err_o pulse, no writeback, IDLE.
//  - ADD result 0x5 to x3 with flush_i=1 -> wb_rd_wen_o=0. Same op with flush_i=0 -> wb x3=5 one cycle later.
//    rst_n low during BUSY -> req drops at once.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage: registers the EX result, runs load/store transactions on a req/ack bus
// with byte-lane alignment and sign extension, and stalls the pipeline while busy.
//
// state | meaning
// IDLE  | accepting ops from EX; pass-through, misalign check or capture
// BUSY  | bus access in flight; waits for ack or timeout
module mem_access_unit #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        ex_rd_wen_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_data_i,
  input  logic [2:0]  ex_mem_size_i,
  input  logic        ex_mem_we_i,
  input  logic        ex_mem_re_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_rd_data_o,
  output logic        wb_rd_wen_o,
  output logic        hold_flag_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
  output logic        bus_err_o
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (BUS_TIMEOUT > 0) ? CW'(BUS_TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_data;
  logic [2:0]    cap_size;
  logic          cap_we;
  logic [4:0]    cap_rd;
  logic          cap_rd_wen;

  logic          ex_mem_op;
  logic          ex_misalign;
  logic          accept;
  logic          done;
  logic          abort;
  logic [1:0]    off;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign ex_mem_op = ex_mem_we_i | ex_mem_re_i;

  // Undefined size codes fall into the word case.
  always_comb begin
    ex_misalign = 1'b0;
    case (ex_mem_size_i)
      3'b000, 3'b100: ex_misalign = 1'b0;
      3'b001, 3'b101: ex_misalign = ex_mem_addr_i[0];
      default:        ex_misalign = (ex_mem_addr_i[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hold_flag_o = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_i && ex_mem_op && !ex_misalign) begin
          accept      = 1'b1;
          hold_flag_o = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if ((BUS_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          hold_flag_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign off = cap_addr[1:0];

  always_comb begin
    be    = 4'b1111;
    wdata = cap_data;
    case (cap_size)
      3'b000, 3'b100: begin
        be    = 4'b0001 << off;
        wdata = {4{cap_data[7:0]}};
      end
      3'b001, 3'b101: begin
        be    = 4'b0011 << off;
        wdata = {2{cap_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = cap_data;
      end
    endcase
  end

  assign ld_byte = bus_rdata_i[{off, 3'b000} +: 8];
  assign ld_half = bus_rdata_i[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = bus_rdata_i;
    case (cap_size)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata_i;
    endcase
  end

  // Bus outputs are qualified by BUSY so an async reset drops them at once.
  assign bus_req_o   = (state == BUSY);
  assign bus_we_o    = bus_req_o & cap_we;
  assign bus_addr_o  = bus_req_o ? {cap_addr[31:2], 2'b00} : 32'd0;
  assign bus_wdata_o = bus_req_o ? wdata : 32'd0;
  assign bus_be_o    = bus_req_o ? be : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == BUSY && state_nxt == BUSY) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr        <= 32'd0;
      cap_data        <= 32'd0;
      cap_size        <= 3'd0;
      cap_we          <= 1'b0;
      cap_rd          <= 5'd0;
      cap_rd_wen      <= 1'b0;
      wb_rd_addr_o    <= 5'd0;
      wb_rd_data_o    <= 32'd0;
      wb_rd_wen_o     <= 1'b0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= 32'd0;
      bus_err_o       <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (state == IDLE) begin
        if (flush_i) begin
          wb_rd_wen_o <= 1'b0;
        end else if (!ex_mem_op) begin
          wb_rd_addr_o <= ex_rd_addr_i;
          wb_rd_data_o <= ex_rd_data_i;
          wb_rd_wen_o  <= ex_rd_wen_i;
        end else if (ex_misalign) begin
          wb_rd_wen_o     <= 1'b0;
          misalign_o      <= 1'b1;
          misalign_addr_o <= ex_mem_addr_i;
        end else if (accept) begin
          wb_rd_wen_o <= 1'b0;
          cap_addr    <= ex_mem_addr_i;
          cap_data    <= ex_mem_data_i;
          cap_size    <= ex_mem_size_i;
          cap_we      <= ex_mem_we_i;
          cap_rd      <= ex_rd_addr_i;
          cap_rd_wen  <= ex_rd_wen_i;
        end
      end else begin
        wb_rd_wen_o <= 1'b0;
        if (done && !cap_we) begin
          wb_rd_addr_o <= cap_rd;
          wb_rd_data_o <= ld_data;
          wb_rd_wen_o  <= cap_rd_wen;
        end
        if (abort) bus_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads/stores, lanes, misalignment, timeout,
// flush and reset during an access. Built with BUS_TIMEOUT=4.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        ex_rd_wen_i;
  logic [31:0] ex_mem_addr_i;
  logic [31:0] ex_mem_data_i;
  logic [2:0]  ex_mem_size_i;
  logic        ex_mem_we_i;
  logic        ex_mem_re_i;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_rd_data_o;
  logic        wb_rd_wen_o;
  logic        hold_flag_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic        bus_err_o;

  int n_cmp = 0;
  int n_err = 0;

  int          hold_cnt, req_cnt, err_cnt, mis_cnt, wen_cnt;
  logic [3:0]  be_seen;
  logic [31:0] addr_seen, wdata_seen;
  logic        we_seen;

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wen_i(ex_rd_wen_i),
    .ex_mem_addr_i(ex_mem_addr_i), .ex_mem_data_i(ex_mem_data_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_mem_we_i(ex_mem_we_i), .ex_mem_re_i(ex_mem_re_i), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_data_o(wb_rd_data_o),
    .wb_rd_wen_o(wb_rd_wen_o), .hold_flag_o(hold_flag_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    ex_rd_addr_i  = 5'd0;
    ex_rd_data_i  = 32'd0;
    ex_rd_wen_i   = 1'b0;
    ex_mem_addr_i = 32'd0;
    ex_mem_data_i = 32'd0;
    ex_mem_size_i = 3'd0;
    ex_mem_we_i   = 1'b0;
    ex_mem_re_i   = 1'b0;
    flush_i       = 1'b0;
  endtask

  // Runs one memory op starting at posedge+1; waits<0 means the bus never acks.
  // Leaves the bench at posedge+1 after the completing edge, with observations recorded.
  task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] size,
                            input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    int ncyc;
    ncyc = (waits >= 0) ? waits + 2 : 8;
    hold_cnt = 0; req_cnt = 0; err_cnt = 0; mis_cnt = 0; wen_cnt = 0;
    be_seen = 4'd0; addr_seen = 32'd0; wdata_seen = 32'd0; we_seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0) begin
        ex_rd_addr_i  = rd;
        ex_rd_data_i  = 32'h0;
        ex_rd_wen_i   = ~we;
        ex_mem_addr_i = addr;
        ex_mem_data_i = data;
        ex_mem_size_i = size;
        ex_mem_we_i   = we;
        ex_mem_re_i   = re;
        flush_i       = 1'b0;
      end else begin
        drive_nop();
      end
      bus_ack_i   = (waits >= 0) && (i == waits + 1);
      bus_rdata_i = rdata;
      #4;
      if (hold_flag_o) hold_cnt++;
      if (bus_req_o) begin
        req_cnt++;
        be_seen    = bus_be_o;
        addr_seen  = bus_addr_o;
        wdata_seen = bus_wdata_o;
        we_seen    = bus_we_o;
      end
      if (bus_err_o) err_cnt++;
      if (misalign_o) mis_cnt++;
      if (i > 0 && wb_rd_wen_o) wen_cnt++;
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", bus_req_o); end
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL rst_hold got=%b exp=0", hold_flag_o); end
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL rst_wen got=%b exp=0", wb_rd_wen_o); end
    n_cmp++; if (wb_rd_data_o !== 32'd0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", wb_rd_data_o); end
    n_cmp++; if (bus_be_o !== 4'd0) begin n_err++; $display("FAIL rst_be got=%b exp=0", bus_be_o); end
    n_cmp++; if ({misalign_o, bus_err_o} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {misalign_o, bus_err_o}); end
  endtask

  task automatic test_store();
    run_access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010, 5'd0, 0, 32'h0);
    n_cmp++; if (be_seen !== 4'b1111) begin n_err++; $display("FAIL sw_be got=%b exp=1111", be_seen); end
    n_cmp++; if (addr_seen !== 32'h100) begin n_err++; $display("FAIL sw_addr got=%h exp=00000100", addr_seen); end
    n_cmp++; if (wdata_seen !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata got=%h exp=deadbeef", wdata_seen); end
    n_cmp++; if (we_seen !== 1'b1) begin n_err++; $display("FAIL sw_we got=%b exp=1", we_seen); end
    n_cmp++; if (hold_cnt !== 1) begin n_err++; $display("FAIL sw_hold got=%0d exp=1", hold_cnt); end
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL sw_wen got=%b exp=0", wb_rd_wen_o); end
    run_access(1'b1, 1'b0, 32'h102, 32'h12345678, 3'b000, 5'd0, 0, 32'h0);
    n_cmp++; if (be_seen !== 4'b0100) begin n_err++; $display("FAIL sb_be got=%b exp=0100", be_seen); end
    n_cmp++; if (wdata_seen !== 32'h78787878) begin n_err++; $display("FAIL sb_wdata got=%h exp=78787878", wdata_seen); end
    run_access(1'b1, 1'b0, 32'h102, 32'h12345678, 3'b001, 5'd0, 0, 32'h0);
    n_cmp++; if (be_seen !== 4'b1100) begin n_err++; $display("FAIL sh_be got=%b exp=1100", be_seen); end
    n_cmp++; if (wdata_seen !== 32'h56785678) begin n_err++; $display("FAIL sh_wdata got=%h exp=56785678", wdata_seen); end
    run_access(1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 3'b010, 5'd9, 0, 32'h11111111);
    n_cmp++; if (we_seen !== 1'b1) begin n_err++; $display("FAIL wer_we got=%b exp=1", we_seen); end
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL wer_wen got=%b exp=0", wb_rd_wen_o); end
  endtask

  task automatic test_load();
    run_access(1'b0, 1'b1, 32'h103, 32'h0, 3'b000, 5'd5, 0, 32'h80FF0011);
    n_cmp++; if (wb_rd_data_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got=%h exp=ffffff80", wb_rd_data_o); end
    n_cmp++; if (wb_rd_addr_o !== 5'd5) begin n_err++; $display("FAIL lb_rd got=%0d exp=5", wb_rd_addr_o); end
    n_cmp++; if (wb_rd_wen_o !== 1'b1) begin n_err++; $display("FAIL lb_wen got=%b exp=1", wb_rd_wen_o); end
    n_cmp++; if (be_seen !== 4'b1000) begin n_err++; $display("FAIL lb_be got=%b exp=1000", be_seen); end
    n_cmp++; if (addr_seen !== 32'h100) begin n_err++; $display("FAIL lb_addr got=%h exp=00000100", addr_seen); end
    run_access(1'b0, 1'b1, 32'h103, 32'h0, 3'b100, 5'd6, 0, 32'h80FF0011);
    n_cmp++; if (wb_rd_data_o !== 32'h00000080) begin n_err++; $display("FAIL lbu_data got=%h exp=00000080", wb_rd_data_o); end
    run_access(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, 5'd7, 3, 32'h80011234);
    n_cmp++; if (wb_rd_data_o !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_data got=%h exp=ffff8001", wb_rd_data_o); end
    n_cmp++; if (hold_cnt !== 4) begin n_err++; $display("FAIL lh_hold got=%0d exp=4", hold_cnt); end
    n_cmp++; if (req_cnt !== 4) begin n_err++; $display("FAIL lh_req got=%0d exp=4", req_cnt); end
    n_cmp++; if (err_cnt !== 0) begin n_err++; $display("FAIL lh_err got=%0d exp=0", err_cnt); end
    n_cmp++; if (wen_cnt !== 0) begin n_err++; $display("FAIL lh_bubble got=%0d exp=0", wen_cnt); end
    run_access(1'b0, 1'b1, 32'h100, 32'h0, 3'b101, 5'd8, 0, 32'h0001F234);
    n_cmp++; if (wb_rd_data_o !== 32'h0000F234) begin n_err++; $display("FAIL lhu_data got=%h exp=0000f234", wb_rd_data_o); end
    run_access(1'b0, 1'b1, 32'h104, 32'h0, 3'b010, 5'd10, 1, 32'h89ABCDEF);
    n_cmp++; if (wb_rd_data_o !== 32'h89ABCDEF) begin n_err++; $display("FAIL lw_data got=%h exp=89abcdef", wb_rd_data_o); end
    n_cmp++; if (wb_rd_addr_o !== 5'd10) begin n_err++; $display("FAIL lw_rd got=%0d exp=10", wb_rd_addr_o); end
  endtask

  task automatic test_misalign();
    run_access(1'b0, 1'b1, 32'h101, 32'h0, 3'b010, 5'd4, 0, 32'h0);
    n_cmp++; if (req_cnt !== 0) begin n_err++; $display("FAIL mis_req got=%0d exp=0", req_cnt); end
    n_cmp++; if (hold_cnt !== 0) begin n_err++; $display("FAIL mis_hold got=%0d exp=0", hold_cnt); end
    n_cmp++; if (mis_cnt !== 1) begin n_err++; $display("FAIL mis_pulse got=%0d exp=1", mis_cnt); end
    n_cmp++; if (misalign_addr_o !== 32'h101) begin n_err++; $display("FAIL mis_addr got=%h exp=00000101", misalign_addr_o); end
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL mis_wen got=%b exp=0", wb_rd_wen_o); end
    run_access(1'b1, 1'b0, 32'h105, 32'h0, 3'b001, 5'd0, 0, 32'h0);
    n_cmp++; if (mis_cnt !== 1) begin n_err++; $display("FAIL mish_pulse got=%0d exp=1", mis_cnt); end
    n_cmp++; if (misalign_addr_o !== 32'h105) begin n_err++; $display("FAIL mish_addr got=%h exp=00000105", misalign_addr_o); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b1, 32'h200, 32'h0, 3'b010, 5'd11, -1, 32'h0);
    n_cmp++; if (req_cnt !== 4) begin n_err++; $display("FAIL to_req got=%0d exp=4", req_cnt); end
    n_cmp++; if (err_cnt !== 1) begin n_err++; $display("FAIL to_err got=%0d exp=1", err_cnt); end
    n_cmp++; if (wen_cnt !== 0) begin n_err++; $display("FAIL to_wen got=%0d exp=0", wen_cnt); end
    n_cmp++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL to_idle got=%b exp=0", bus_req_o); end
  endtask

  task automatic test_flush();
    drive_nop();
    ex_rd_addr_i = 5'd7; ex_rd_data_i = 32'd9; ex_rd_wen_i = 1'b1;
    #4;
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL pass_hold got=%b exp=0", hold_flag_o); end
    @(posedge clk); #1;
    n_cmp++; if ({wb_rd_addr_o, wb_rd_data_o, wb_rd_wen_o} !== {5'd7, 32'd9, 1'b1}) begin
      n_err++; $display("FAIL pass_wb got=%0d/%h/%b exp=7/00000009/1", wb_rd_addr_o, wb_rd_data_o, wb_rd_wen_o); end
    ex_rd_addr_i = 5'd3; ex_rd_data_i = 32'd5; flush_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL flush_wen got=%b exp=0", wb_rd_wen_o); end
    flush_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({wb_rd_addr_o, wb_rd_data_o, wb_rd_wen_o} !== {5'd3, 32'd5, 1'b1}) begin
      n_err++; $display("FAIL add_wb got=%0d/%h/%b exp=3/00000005/1", wb_rd_addr_o, wb_rd_data_o, wb_rd_wen_o); end
    ex_rd_wen_i = 1'b0; ex_mem_re_i = 1'b1; ex_mem_size_i = 3'b010; ex_mem_addr_i = 32'h300; flush_i = 1'b1;
    #4;
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL flush_ld_hold got=%b exp=0", hold_flag_o); end
    @(posedge clk); #1;
    drive_nop();
    n_cmp++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL flush_ld_req got=%b exp=0", bus_req_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    drive_nop();
    ex_rd_addr_i = 5'd12; ex_rd_wen_i = 1'b1; ex_mem_re_i = 1'b1;
    ex_mem_size_i = 3'b010; ex_mem_addr_i = 32'h400;
    @(posedge clk); #1;
    drive_nop();
    #3;
    n_cmp++; if (bus_req_o !== 1'b1) begin n_err++; $display("FAIL rmid_busy got=%b exp=1", bus_req_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_req got=%b exp=0", bus_req_o); end
    #3;
    rst_n = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    n_cmp++; if (wb_rd_wen_o !== 1'b0) begin n_err++; $display("FAIL rmid_wen got=%b exp=0", wb_rd_wen_o); end
    n_cmp++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_idle got=%b exp=0", bus_req_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_nop();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
